// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone memory-test master.
package wb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrGap,
    StRdReq,
    StRdGap,
    StFinish
  } state_e;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  function automatic logic [31:0] pattern(input logic [31:0] addr, input logic inv,
                                          input logic [31:0] seed);
    return (inv ? ~addr : addr) ^ seed;
  endfunction

endpackage

// File: rtl/wb_memtest_master_if.sv
// Wishbone classic bus bundle between the memory-test master and its target.
interface wb_memtest_master_if;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/wb_memtest_cmp.sv
// Read-back comparator: saturating mismatch counter plus first-failure capture.
module wb_memtest_cmp (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        valid,
  input  logic [31:0] addr,
  input  logic [31:0] exp,
  input  logic [31:0] got,
  output logic [15:0] err_count,
  output logic [31:0] first_err_adr,
  output logic [31:0] first_err_dat
);

  logic        mismatch;
  logic [15:0] err_count_q;
  logic [31:0] first_adr_q;
  logic [31:0] first_dat_q;

  assign mismatch = valid && (got != exp);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      err_count_q <= 16'h0000;
      first_adr_q <= 32'h0000_0000;
      first_dat_q <= 32'h0000_0000;
    end else if (mismatch) begin
      if (err_count_q != 16'hFFFF) begin
        err_count_q <= err_count_q + 16'd1;
      end
      // The counter saturates rather than wraps, so zero always means "no capture yet".
      if (err_count_q == 16'h0000) begin
        first_adr_q <= addr;
        first_dat_q <= got;
      end
    end
  end

  assign err_count     = err_count_q;
  assign first_err_adr = first_adr_q;
  assign first_err_dat = first_dat_q;

endmodule

// File: rtl/wb_memtest_master.sv
// Wishbone initiator: writes an address-derived pattern over a word range, then
// reads it back and reports mismatches and transfer timeouts.
module wb_memtest_master
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [31:0] SEED    = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [31:0]                base_adr,
  input  logic [15:0]                word_count,
  input  logic                       inv_mode,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic [15:0]                err_count,
  output logic [31:0]                first_err_adr,
  output logic [31:0]                first_err_dat,
  wb_memtest_master_if.master        bus
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [31:0]       base_q, base_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       idx_q, idx_d;
  logic              inv_q, inv_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;

  logic              cmp_clear;
  logic              cmp_valid;
  logic [31:0]       cur_adr;
  logic [31:0]       cur_pat;
  logic              req;
  logic              last_word;

  assign cur_adr   = base_q + {14'd0, idx_q, 2'b00};
  assign cur_pat   = pattern(cur_adr, inv_q, SEED);
  assign last_word = (idx_q == count_q - 16'd1);
  assign req       = (state_q == StWrReq) || (state_q == StRdReq);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    idx_d     = idx_q;
    inv_d     = inv_q;
    timer_d   = timer_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    cmp_clear = 1'b0;
    cmp_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d    = base_adr & 32'hFFFF_FFFC;
          count_d   = word_count;
          inv_d     = inv_mode;
          idx_d     = 16'd0;
          timer_d   = '0;
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          cmp_clear = 1'b1;
          state_d   = (word_count == 16'd0) ? StFinish : StWrReq;
        end
      end
      StWrReq, StRdReq: begin
        // An ack arriving on the final timer cycle still counts as a completed transfer.
        if (bus.wb_ack_i) begin
          cmp_valid = (state_q == StRdReq);
          state_d   = (state_q == StWrReq) ? StWrGap : StRdGap;
        end else if (timer_q == TimerMax) begin
          timeout_d = 1'b1;
          state_d   = StFinish;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWrGap: begin
        timer_d = '0;
        if (last_word) begin
          idx_d   = 16'd0;
          state_d = StRdReq;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = StWrReq;
        end
      end
      StRdGap: begin
        timer_d = '0;
        if (last_word) begin
          state_d = StFinish;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = StRdReq;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = !timeout_q && (err_count == 16'h0000);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      base_q    <= 32'h0000_0000;
      count_q   <= 16'h0000;
      idx_q     <= 16'h0000;
      inv_q     <= 1'b0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      inv_q     <= inv_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
    end
  end

  wb_memtest_cmp u_cmp (
    .clk           (clk),
    .reset         (reset),
    .clear         (cmp_clear),
    .valid         (cmp_valid),
    .addr          (cur_adr),
    .exp           (cur_pat),
    .got           (bus.wb_dat_i),
    .err_count     (err_count),
    .first_err_adr (first_err_adr),
    .first_err_dat (first_err_dat)
  );

  assign bus.wb_cyc_o = req;
  assign bus.wb_stb_o = req;
  assign bus.wb_we_o  = (state_q == StWrReq);
  assign bus.wb_adr_o = req ? cur_adr : 32'h0000_0000;
  assign bus.wb_sel_o = WB_SEL_ALL;
  assign bus.wb_dat_o = (state_q == StWrReq) ? cur_pat : 32'h0000_0000;

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_wb_memtest_master.sv
// Bench for wb_memtest_master: memory responder with configurable ack latency and
// read corruption, checked against a plain-arithmetic model of the test sequence.
module tb_wb_memtest_master;

  localparam int unsigned TMO  = 16;
  localparam logic [31:0] SEED = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_adr;
  logic [15:0] word_count;
  logic        inv_mode;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] first_err_adr, first_err_dat;

  wb_memtest_master_if bus ();

  wb_memtest_master #(
    .TIMEOUT (TMO),
    .SEED    (SEED)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_adr      (base_adr),
    .word_count    (word_count),
    .inv_mode      (inv_mode),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .err_count     (err_count),
    .first_err_adr (first_err_adr),
    .first_err_dat (first_err_dat),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: small word memory indexed by address bits [7:2].
  logic [31:0] mem [64];
  logic [63:0] corrupt_map;
  logic [31:0] corrupt_x;
  int unsigned lat;
  logic        ack_en;
  int unsigned wcnt;

  always @(posedge clk) begin
    if (reset || !(bus.wb_cyc_o && bus.wb_stb_o) || bus.wb_ack_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  assign bus.wb_ack_i = bus.wb_cyc_o && bus.wb_stb_o && ack_en && (wcnt == lat);
  assign bus.wb_dat_i = mem[bus.wb_adr_o[7:2]] ^
                        (corrupt_map[bus.wb_adr_o[7:2]] ? corrupt_x : 32'h0);

  int n_checks = 0;
  int n_fail   = 0;

  // Observations from one operation.
  logic        obs_we[$];
  logic [31:0] obs_adr[$];
  logic [31:0] obs_dat[$];
  int          done_at, done_cnt, max_run, cyc_cycles;

  function automatic logic [31:0] m_adr(input logic [31:0] b, input int i);
    logic [31:0] a;
    a = b & 32'hFFFF_FFFC;
    return a + 32'(4 * i);
  endfunction

  function automatic logic [31:0] m_pat(input logic [31:0] a, input logic inv);
    return (inv ? ~a : a) ^ SEED;
  endfunction

  task automatic run_op(input logic [31:0] b, input logic [15:0] n, input logic inv,
                        input int extra_at, input int budget);
    int run;
    int t;
    run = 0;
    t = 0;
    obs_we.delete();
    obs_adr.delete();
    obs_dat.delete();
    done_at = -1;
    done_cnt = 0;
    max_run = 0;
    cyc_cycles = 0;
    base_adr = b;
    word_count = n;
    inv_mode = inv;
    start = 1'b1;
    while (t < budget && (done_at < 0 || t < done_at + 3)) begin
      @(posedge clk);
      @(negedge clk);
      t++;
      start = (t == extra_at);
      if (t == extra_at) begin
        base_adr = ~b;
        word_count = n + 16'd1;
        inv_mode = ~inv;
      end
      if (bus.wb_cyc_o) begin
        cyc_cycles++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i) begin
        obs_we.push_back(bus.wb_we_o);
        obs_adr.push_back(bus.wb_adr_o);
        obs_dat.push_back(bus.wb_we_o ? bus.wb_dat_o : bus.wb_dat_i);
        if (bus.wb_we_o) mem[bus.wb_adr_o[7:2]] = bus.wb_dat_o;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = t;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, busy, done, pass, timeout} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000000",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, busy, done, pass, timeout});
    end
    n_checks++;
    if (bus.wb_sel_o !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_sel: got %h want f", bus.wb_sel_o);
    end
    n_checks++;
    if ({bus.wb_adr_o, bus.wb_dat_o, err_count, first_err_adr, first_err_dat} !== 144'h0) begin
      n_fail++;
      $display("FAIL reset_words: adr %h dat %h err %h fea %h fed %h want all 0",
               bus.wb_adr_o, bus.wb_dat_o, err_count, first_err_adr, first_err_dat);
    end
  endtask

  task automatic test_basic();
    lat = 0;
    run_op(32'h100, 16'd4, 1'b0, 5, 200);
    n_checks++;
    if (obs_adr.size() !== 8) begin
      n_fail++;
      $display("FAIL basic_ntxn: got %0d want 8", obs_adr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (obs_we[i] !== (i < 4) || obs_adr[i] !== m_adr(32'h100, i % 4) ||
            (i < 4 && obs_dat[i] !== 32'h100 + 32'(4 * i))) begin
          n_fail++;
          $display("FAIL basic_txn%0d: got we=%b adr=%h dat=%h want we=%b adr=%h", i,
                   obs_we[i], obs_adr[i], obs_dat[i], i < 4, m_adr(32'h100, i % 4));
        end
      end
    end
    n_checks++;
    if (done_at !== 18 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL basic_done: got at=%0d cnt=%0d want at=18 cnt=1", done_at, done_cnt);
    end
    n_checks++;
    if (cyc_cycles !== 8) begin
      n_fail++;
      $display("FAIL basic_cyc_cycles: got %0d want 8", cyc_cycles);
    end
    n_checks++;
    if ({pass, timeout, busy} !== 3'b100 || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL basic_status: got pass=%b tmo=%b busy=%b err=%0d want 1 0 0 0",
               pass, timeout, busy, err_count);
    end
  endtask

  task automatic test_latency();
    lat = 3;
    run_op(32'h100, 16'd4, 1'b1, -1, 300);
    n_checks++;
    if (obs_dat.size() < 1 || obs_dat[0] !== 32'hFFFF_FEFF) begin
      n_fail++;
      $display("FAIL lat_first_wdat: got %h want ffff_feff",
               obs_dat.size() > 0 ? obs_dat[0] : 32'hx);
    end
    n_checks++;
    if (done_at !== 42 || max_run !== 4 || cyc_cycles !== 32) begin
      n_fail++;
      $display("FAIL lat_timing: got done=%0d run=%0d cyc=%0d want 42 4 32",
               done_at, max_run, cyc_cycles);
    end
    n_checks++;
    if (pass !== 1'b1 || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL lat_pass: got pass=%b err=%0d want 1 0", pass, err_count);
    end
    lat = 0;
  endtask

  task automatic test_corrupt();
    corrupt_map = 64'h0;
    corrupt_map[1] = 1'b1;
    corrupt_map[3] = 1'b1;
    corrupt_x = 32'h1;
    run_op(32'h100, 16'd4, 1'b0, -1, 200);
    n_checks++;
    if (err_count !== 16'd2 || pass !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL corrupt_status: got err=%0d pass=%b tmo=%b want 2 0 0",
               err_count, pass, timeout);
    end
    n_checks++;
    if (first_err_adr !== 32'h104 || first_err_dat !== 32'h105) begin
      n_fail++;
      $display("FAIL corrupt_first: got adr=%h dat=%h want 104 105",
               first_err_adr, first_err_dat);
    end
    corrupt_map = 64'h0;
  endtask

  task automatic test_ack_at_limit();
    lat = TMO - 1;
    run_op(32'h40, 16'd1, 1'b0, -1, 200);
    n_checks++;
    if (pass !== 1'b1 || timeout !== 1'b0 || done_at !== 36) begin
      n_fail++;
      $display("FAIL ack_at_limit: got pass=%b tmo=%b done=%0d want 1 0 36",
               pass, timeout, done_at);
    end
    lat = 0;
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    run_op(32'h200, 16'd2, 1'b0, -1, 200);
    n_checks++;
    if (max_run !== TMO || obs_adr.size() !== 0) begin
      n_fail++;
      $display("FAIL tmo_stb_run: got run=%0d txn=%0d want %0d 0", max_run, obs_adr.size(), TMO);
    end
    n_checks++;
    if (done_at !== 18 || done_cnt !== 1 || timeout !== 1'b1 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_status: got done=%0d cnt=%0d tmo=%b pass=%b want 18 1 1 0",
               done_at, done_cnt, timeout, pass);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_zero_count();
    run_op(32'h300, 16'd0, 1'b0, 1, 50);
    n_checks++;
    if (cyc_cycles !== 0 || done_at !== 2 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL zero_count: got cyc=%0d done=%0d cnt=%0d want 0 2 1",
               cyc_cycles, done_at, done_cnt);
    end
    n_checks++;
    if (pass !== 1'b1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_status: got pass=%b tmo=%b want 1 0", pass, timeout);
    end
  endtask

  task automatic test_wrap();
    run_op(32'hFFFF_FFF8, 16'd4, 1'b0, -1, 200);
    n_checks++;
    if (obs_adr.size() !== 8) begin
      n_fail++;
      $display("FAIL wrap_ntxn: got %0d want 8", obs_adr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_adr[i] !== m_adr(32'hFFFF_FFF8, i) || obs_adr[i + 4] !== m_adr(32'hFFFF_FFF8, i))
        begin
          n_fail++;
          $display("FAIL wrap_adr%0d: got %h/%h want %h", i, obs_adr[i], obs_adr[i + 4],
                   m_adr(32'hFFFF_FFF8, i));
        end
      end
    end
    n_checks++;
    if (pass !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_pass: got %b want 1", pass);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int dcnt;
    found = 0;
    dcnt = 0;
    base_adr = 32'hFFFF_FFF8;
    word_count = 16'd4;
    inv_mode = 1'b0;
    start = 1'b1;
    for (int t = 0; t < 100 && !found; t++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (bus.wb_cyc_o && !bus.wb_we_o) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL rstmid_reach_read: got none want read phase");
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, busy, done, pass, timeout} !== 6'b0 ||
        err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rstmid_cleared: got cyc=%b stb=%b busy=%b done=%b err=%0d want 0",
               bus.wb_cyc_o, bus.wb_stb_o, busy, done, err_count);
    end
    reset = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (done || bus.wb_cyc_o) dcnt++;
    end
    n_checks++;
    if (dcnt !== 0) begin
      n_fail++;
      $display("FAIL rstmid_no_done: got %0d active cycles want 0", dcnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] b;
    logic [15:0] n;
    logic        inv;
    int          exp_err;
    logic [31:0] exp_fa, exp_fd, a;
    for (int it = 0; it < 8; it++) begin
      b = $urandom;
      n = 16'($urandom_range(1, 24));
      inv = 1'($urandom);
      lat = $urandom_range(0, 4);
      corrupt_map = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      corrupt_x = $urandom | 32'h1;
      exp_err = 0;
      exp_fa = 0;
      exp_fd = 0;
      for (int i = 0; i < int'(n); i++) begin
        a = m_adr(b, i);
        if (corrupt_map[a[7:2]]) begin
          if (exp_err == 0) begin
            exp_fa = a;
            exp_fd = m_pat(a, inv) ^ corrupt_x;
          end
          exp_err++;
        end
      end
      run_op(b, n, inv, -1, 1000);
      n_checks++;
      if (obs_adr.size() !== 2 * int'(n)) begin
        n_fail++;
        $display("FAIL rnd%0d_ntxn: got %0d want %0d", it, obs_adr.size(), 2 * int'(n));
      end else begin
        for (int i = 0; i < 2 * int'(n); i++) begin
          a = m_adr(b, i % int'(n));
          n_checks++;
          if (obs_we[i] !== (i < int'(n)) || obs_adr[i] !== a ||
              (i < int'(n) && obs_dat[i] !== m_pat(a, inv))) begin
            n_fail++;
            $display("FAIL rnd%0d_txn%0d: got we=%b adr=%h dat=%h want adr=%h pat=%h", it, i,
                     obs_we[i], obs_adr[i], obs_dat[i], a, m_pat(a, inv));
          end
        end
      end
      n_checks++;
      if (done_at !== 2 + int'(n) * 2 * (int'(lat) + 2) || done_cnt !== 1) begin
        n_fail++;
        $display("FAIL rnd%0d_done: got at=%0d cnt=%0d want %0d 1", it, done_at, done_cnt,
                 2 + int'(n) * 2 * (int'(lat) + 2));
      end
      n_checks++;
      if (err_count !== 16'(exp_err) || pass !== (exp_err == 0) || timeout !== 1'b0 ||
          (exp_err > 0 && (first_err_adr !== exp_fa || first_err_dat !== exp_fd))) begin
        n_fail++;
        $display("FAIL rnd%0d_status: got err=%0d pass=%b fa=%h fd=%h want %0d %b %h %h", it,
                 err_count, pass, first_err_adr, first_err_dat, exp_err, exp_err == 0,
                 exp_fa, exp_fd);
      end
    end
    corrupt_map = 64'h0;
    lat = 0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_adr = 32'h0;
    word_count = 16'h0;
    inv_mode = 1'b0;
    corrupt_map = 64'h0;
    corrupt_x = 32'h0;
    lat = 0;
    ack_en = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    test_reset();
    test_basic();
    test_latency();
    test_corrupt();
    test_ack_at_limit();
    test_timeout();
    test_zero_count();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
